// File: rtl/err_tlm_rx.sv
// Receiver for the error-processor telemetry tag stream: deserialises MSB-first
// tag words framed by ETTS/ETCC, checks odd parity and keeps saturating stats.
module err_tlm_rx #(
  parameter int WORD_BITS = 26,
  parameter int PARITY    = 1,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 BIT_STB,
  input  logic                 ETTS,
  input  logic                 TAGS,
  input  logic                 ETCC,
  output logic [WORD_BITS-1:0] WORD,
  output logic                 WORD_VLD,
  output logic                 PAR_ERR,
  output logic                 FRAME_ERR,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     FRAME_CNT,
  output logic [CNT_W-1:0]     ERR_CNT,
  output logic [1:0]           dbg_state
);

  // Handshake: WORD_VLD is a one-clock valid pulse with no ready; the consumer
  // must take WORD in that cycle (WORD itself holds until the next good frame).

  localparam int BC_W = $clog2(WORD_BITS + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;

  state_t               state, state_nxt;
  logic                 etts_q;
  logic [WORD_BITS-1:0] sh;
  logic [BC_W-1:0]      bit_cnt;
  logic [TM_W-1:0]      tmo_cnt;

  logic                 start, last_data, tmo_hit, in_frame;
  logic                 frame_err_nxt, word_vld_nxt, par_err_nxt;
  logic [WORD_BITS-1:0] shifted, word_in;

  assign start     = ETTS & ~etts_q;
  assign shifted   = {sh[WORD_BITS-2:0], TAGS};
  assign last_data = (bit_cnt == BC_W'(WORD_BITS - 1));
  assign tmo_hit   = (tmo_cnt == TM_W'(TIMEOUT - 1));
  assign BUSY      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  // Priority: ETTS low aborts first, then strobe handling, then timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        if (!ETTS) state_nxt = IDLE;
        else if (BIT_STB) begin
          if (last_data) begin
            if (PARITY != 0) state_nxt = ETCC ? IDLE : PAR;
            else             state_nxt = ETCC ? DONE : IDLE;
          end else if (ETCC) begin
            state_nxt = IDLE;
          end
        end else if (tmo_hit) state_nxt = IDLE;
      end
      PAR: begin
        if (!ETTS)        state_nxt = IDLE;
        else if (BIT_STB) state_nxt = ETCC ? DONE : IDLE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Any exit from SHIFT/PAR other than into DONE is an aborted frame.
  always_comb begin
    in_frame      = (state == SHIFT) || (state == PAR);
    frame_err_nxt = in_frame && (state_nxt == IDLE);
    word_vld_nxt  = in_frame && (state_nxt == DONE);
    par_err_nxt   = (PARITY != 0) && word_vld_nxt && !(^{sh, TAGS});
    word_in       = (state == PAR) ? sh : shifted;
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      etts_q    <= 1'b0;
      sh        <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      WORD      <= '0;
      WORD_VLD  <= 1'b0;
      PAR_ERR   <= 1'b0;
      FRAME_ERR <= 1'b0;
      FRAME_CNT <= '0;
      ERR_CNT   <= '0;
    end else begin
      etts_q    <= ETTS;
      WORD_VLD  <= word_vld_nxt;
      PAR_ERR   <= par_err_nxt;
      FRAME_ERR <= frame_err_nxt;
      if (word_vld_nxt) WORD <= word_in;
      if (word_vld_nxt && (FRAME_CNT != '1)) FRAME_CNT <= FRAME_CNT + 1'b1;
      if ((par_err_nxt || frame_err_nxt) && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + 1'b1;

      if (state == IDLE) begin
        if (start) begin
          sh      <= '0;
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
      end else if (in_frame) begin
        if (BIT_STB) tmo_cnt <= '0;
        else         tmo_cnt <= tmo_cnt + 1'b1;
        if ((state == SHIFT) && BIT_STB) begin
          sh      <= shifted;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_err_tlm_rx.sv
// Bench for err_tlm_rx: directed frames with hand-computed words/parity, an
// expected-event queue drained by a monitor, plus a CNT_W=2 saturation copy.
module tb_err_tlm_rx;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST, BIT_STB, ETTS, TAGS, ETCC;
  logic [25:0] WORD, s_word;
  logic        WORD_VLD, PAR_ERR, FRAME_ERR, BUSY;
  logic        s_vld, s_perr, s_ferr, s_busy;
  logic [7:0]  FRAME_CNT, ERR_CNT;
  logic [1:0]  s_fcnt, s_ecnt, dbg_state, s_dbg;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [44:0] exp_q[$];
  int          exp_cyc_q[$];

  logic [25:0] m_word;
  logic [7:0]  m_f, m_e;
  logic [1:0]  s_f, s_e;

  logic [25:0] vec_d [4] = '{26'h2AAAAAA, 26'h3FFFFFF, 26'h0000001, 26'h1234567};
  logic        vec_p [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  err_tlm_rx dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .BIT_STB(BIT_STB), .ETTS(ETTS),
    .TAGS(TAGS), .ETCC(ETCC), .WORD(WORD), .WORD_VLD(WORD_VLD),
    .PAR_ERR(PAR_ERR), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY),
    .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT), .dbg_state(dbg_state)
  );

  err_tlm_rx #(.CNT_W(2)) dut_sat (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .BIT_STB(BIT_STB), .ETTS(ETTS),
    .TAGS(TAGS), .ETCC(ETCC), .WORD(s_word), .WORD_VLD(s_vld),
    .PAR_ERR(s_perr), .FRAME_ERR(s_ferr), .BUSY(s_busy),
    .FRAME_CNT(s_fcnt), .ERR_CNT(s_ecnt), .dbg_state(s_dbg)
  );

  // clock / reset
  always #5 SIM_CLK = ~SIM_CLK;
  always @(posedge SIM_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] inc_sat(input logic [7:0] v, input logic [7:0] maxv);
    return (v == maxv) ? v : v + 8'd1;
  endfunction

  // kind 1 = word delivered (perr selects parity error), kind 2 = frame error
  task automatic expect_evt(input int kind, input logic [25:0] d, input logic perr, input int at_cyc);
    if (kind == 1) begin
      m_word = d;
      m_f = inc_sat(m_f, 8'hFF);
      s_f = 2'(inc_sat({6'd0, s_f}, 8'd3));
      if (perr) begin
        m_e = inc_sat(m_e, 8'hFF);
        s_e = 2'(inc_sat({6'd0, s_e}, 8'd3));
      end
    end else begin
      m_e = inc_sat(m_e, 8'hFF);
      s_e = 2'(inc_sat({6'd0, s_e}, 8'd3));
    end
    exp_q.push_back({m_word, 1'(kind == 1), 1'(kind == 1 && perr), 1'(kind == 2), m_f, m_e});
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic clear_model();
    m_word = '0; m_f = '0; m_e = '0; s_f = '0; s_e = '0;
  endtask

  // scoreboard monitor
  task automatic run_monitor();
    logic [44:0] act, e;
    int ec;
    forever begin
      @(negedge SIM_CLK);
      if (!SIM_RST && (WORD_VLD || PAR_ERR || FRAME_ERR)) begin
        act = {WORD, WORD_VLD, PAR_ERR, FRAME_ERR, FRAME_CNT, ERR_CNT};
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'(act), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("event", 64'(act), 64'(e));
          check("event_cycle", 64'(cyc), 64'(ec));
        end
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge SIM_CLK);
    SIM_RST = 1'b1; ETTS = 1'b0; BIT_STB = 1'b0; ETCC = 1'b0; TAGS = 1'b0;
    @(negedge SIM_CLK);
    SIM_RST = 1'b0;
    clear_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"}, 64'(WORD), 64'(0));
    check({tag, "_word_vld"}, 64'(WORD_VLD), 64'(0));
    check({tag, "_par_err"}, 64'(PAR_ERR), 64'(0));
    check({tag, "_frame_err"}, 64'(FRAME_ERR), 64'(0));
    check({tag, "_busy"}, 64'(BUSY), 64'(0));
    check({tag, "_frame_cnt"}, 64'(FRAME_CNT), 64'(0));
    check({tag, "_err_cnt"}, 64'(ERR_CNT), 64'(0));
  endtask

  // Sends nbits sampled bits (26 data MSB first, then parity); ETCC on bit etcc_idx.
  task automatic send_frame(input logic [25:0] d, input logic p, input int etcc_idx,
                            input int nbits, input int kind, input logic perr,
                            output int last_c);
    last_c = cyc;
    @(negedge SIM_CLK);
    ETTS = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge SIM_CLK);
      BIT_STB = 1'b1;
      TAGS    = (i < 26) ? d[25 - i] : p;
      ETCC    = (i == etcc_idx);
      last_c  = cyc;
      if (i == nbits - 1 && kind != 0) expect_evt(kind, d, perr, cyc + 1);
      @(negedge SIM_CLK);
      BIT_STB = 1'b0; ETCC = 1'b0; TAGS = 1'b0;
    end
  endtask

  task automatic end_frame();
    @(negedge SIM_CLK);
    ETTS = 1'b0;
    repeat (2) @(negedge SIM_CLK);
  endtask

  initial begin
    int lc;
    SIM_RST = 1'b1; BIT_STB = 1'b0; ETTS = 1'b0; TAGS = 1'b0; ETCC = 1'b0;
    clear_model();
    fork
      run_monitor();
    join_none
    repeat (3) @(negedge SIM_CLK);
    check_all_zero("reset");
    SIM_RST = 1'b0;

    // good frame, then the same data with a wrong parity bit
    send_frame(26'h2AAAAAA, 1'b0, 26, 27, 1, 1'b0, lc); end_frame();
    do_reset();
    send_frame(26'h2AAAAAA, 1'b1, 26, 27, 1, 1'b1, lc); end_frame();

    for (int i = 0; i < 4; i++) begin
      send_frame(vec_d[i], vec_p[i], 26, 27, 1, 1'b0, lc); end_frame();
      send_frame(vec_d[i], ~vec_p[i], 26, 27, 1, 1'b1, lc); end_frame();
    end

    // ETCC on data bit 10
    send_frame(vec_d[3], 1'b0, 10, 11, 2, 1'b0, lc);
    check("early_etcc_busy", 64'(BUSY), 64'(0));
    end_frame();

    // ETCC missing on the parity bit
    send_frame(vec_d[1], 1'b1, -1, 27, 2, 1'b0, lc); end_frame();

    // ETTS dropped after 3 bits
    send_frame(vec_d[2], 1'b0, -1, 3, 0, 1'b0, lc);
    check("mid_frame_busy", 64'(BUSY), 64'(1));
    @(negedge SIM_CLK);
    ETTS = 1'b0;
    expect_evt(2, '0, 1'b0, cyc + 1);
    repeat (2) @(negedge SIM_CLK);
    check("etts_drop_busy", 64'(BUSY), 64'(0));

    // strobes stop after 5 bits with ETTS held high
    send_frame(vec_d[3], 1'b1, -1, 5, 0, 1'b0, lc);
    expect_evt(2, '0, 1'b0, lc + 65);
    repeat (70) @(negedge SIM_CLK);
    check("timeout_busy", 64'(BUSY), 64'(0));
    end_frame();
    send_frame(vec_d[3], 1'b1, 26, 27, 1, 1'b0, lc); end_frame();

    // ETTS held high after DONE must not start a new frame
    send_frame(26'h2AAAAAA, 1'b0, 26, 27, 1, 1'b0, lc);
    repeat (10) @(negedge SIM_CLK);
    check("no_retrigger_busy", 64'(BUSY), 64'(0));
    end_frame();

    // reset at bit 12
    send_frame(vec_d[1], 1'b1, -1, 12, 0, 1'b0, lc);
    @(negedge SIM_CLK);
    SIM_RST = 1'b1; ETTS = 1'b0;
    @(negedge SIM_CLK);
    SIM_RST = 1'b0;
    clear_model();
    check_all_zero("mid_reset");
    send_frame(vec_d[1], 1'b1, 26, 27, 1, 1'b0, lc); end_frame();

    // saturation on the CNT_W=2 copy
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_frame(26'h2AAAAAA, 1'b0, 26, 27, 1, 1'b0, lc); end_frame();
      check("sat_frame_cnt", 64'(s_fcnt), 64'(s_f));
    end
    check("sat_frame_cnt_held", 64'(s_fcnt), 64'(3));
    for (int i = 0; i < 4; i++) begin
      send_frame(26'h2AAAAAA, 1'b1, 26, 27, 1, 1'b1, lc); end_frame();
      check("sat_err_cnt", 64'(s_ecnt), 64'(s_e));
    end
    check("sat_err_cnt_held", 64'(s_ecnt), 64'(3));
    check("sat_frame_cnt_final", 64'(s_fcnt), 64'(3));

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge SIM_CLK);
    if (exp_q.size() != 0) check("drain_pending", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
